// File: rtl/matc_unloader.sv
// Drains the result RAM in address order as a valid/ready word stream and accumulates an XOR checksum.
// Reads issue one per clock through a 2-entry skid buffer that covers the 1-cycle RAM latency.
module matc_unloader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 19,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int PTR_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
  } entry_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_idx;
  entry_t            ent0, ent1;
  logic [1:0]        occ;
  logic [1:0]        pending;
  logic              launch;
  logic              pop;
  logic              push;
  logic              tail_is_head;
  entry_t            incoming;

  assign launch       = start && ((state == IDLE) || (state == DONE));
  assign pop          = out_valid && out_ready;
  assign push         = inflight;
  assign incoming     = '{data: ram_data, idx: inflight_idx};
  assign tail_is_head = ((occ - {1'b0, pop}) == 2'd0);
  // Counting the same-cycle pop keeps one read per clock in steady state
  // (one word held, one in flight) without ever overfilling the buffer.
  assign pending      = occ + {1'b0, inflight} - {1'b0, pop};
  assign ram_addr     = rd_ptr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        ram_rd_en = (rd_ptr < PTR_W'(DEPTH)) && (pending < 2'd2);
        if (pop && out_last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = ent0.data;
  assign out_index = ent0.idx;
  assign out_last  = out_valid && (ent0.idx == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      occ          <= 2'd0;
      ent0         <= '0;
      ent1         <= '0;
      checksum     <= '0;
    end else if (launch) begin
      rd_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      occ          <= 2'd0;
      ent0         <= '0;
      ent1         <= '0;
      checksum     <= '0;
    end else begin
      inflight     <= ram_rd_en;
      inflight_idx <= ram_addr;
      if (ram_rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop) checksum <= checksum ^ ent0.data;
      occ <= occ + {1'b0, push} - {1'b0, pop};
      // Head is always ent0: a pop shifts ent1 forward, and the returning
      // word lands in whichever slot is the tail after that shift.
      if (pop) ent0 <= ent1;
      if (push) begin
        if (tail_is_head) ent0 <= incoming;
        else              ent1 <= incoming;
      end
    end
  end

endmodule

// File: tb/tb_matc_unloader.sv
// Directed bench for matc_unloader: RAM model with 1-cycle read latency, per-scenario tasks with inline checks.
module tb_matc_unloader;
  localparam int AW = 6;
  localparam int DW = 19;
  localparam int N  = 64;

  logic          clk, rst_n, start, ram_rd_en, out_valid, out_ready, out_last, busy, done;
  logic [AW-1:0] ram_addr, out_index;
  logic [DW-1:0] ram_data, out_data, checksum;

  logic [DW-1:0] mem [N];
  int            n_cmp, n_bad;
  longint        t0;

  logic [DW-1:0] hs_dat[$];
  logic [AW-1:0] hs_idx[$];
  logic          hs_last[$];
  longint        hs_t[$];
  logic [AW-1:0] rd_a[$];
  longint        rd_t[$];

  matc_unloader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_data <= mem[ram_addr];

  // Log handshakes and reads at the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      hs_dat.push_back(out_data);
      hs_idx.push_back(out_index);
      hs_last.push_back(out_last);
      hs_t.push_back(longint'($time));
    end
    if (ram_rd_en) begin
      rd_a.push_back(ram_addr);
      rd_t.push_back(longint'($time));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic start_run();
    hs_dat.delete(); hs_idx.delete(); hs_last.delete(); hs_t.delete();
    rd_a.delete(); rd_t.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); t0 = longint'($time);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output longint dedge);
    dedge = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        dedge = (longint'($time) - 5 - t0) / 10;
        break;
      end
    end
    if (dedge < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: done=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({ram_rd_en, ram_addr} !== '0) begin n_bad++; $display("FAIL rst_ram: rd_en=%b addr=%0d, required 0/0", ram_rd_en, ram_addr); end
    n_cmp++; if ({out_valid, out_last, out_index, out_data} !== '0) begin n_bad++; $display("FAIL rst_out: valid=%b last=%b idx=%0d data=%h, required all 0", out_valid, out_last, out_index, out_data); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL rst_status: busy=%b done=%b, required 0/0", busy, done); end
    n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL rst_checksum: %h, required 0", checksum); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({out_valid, busy, ram_rd_en} !== 3'b000) begin n_bad++; $display("FAIL idle_quiet: valid=%b busy=%b rd_en=%b, required 000", out_valid, busy, ram_rd_en); end
  endtask

  task automatic test_sequential();
    longint de;
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    out_ready = 1'b1;
    start_run();
    @(negedge clk);
    n_cmp++; if ({ram_rd_en, ram_addr, busy} !== {1'b1, 6'd0, 1'b1}) begin n_bad++; $display("FAIL seq_first_read: rd_en=%b addr=%0d busy=%b, required 1/0/1", ram_rd_en, ram_addr, busy); end
    wait_done(200, de);
    n_cmp++; if (de != 66) begin n_bad++; $display("FAIL seq_done_edge: E%0d, required E66", de); end
    n_cmp++; if (hs_dat.size() != N) begin n_bad++; $display("FAIL seq_beats: %0d, required 64", hs_dat.size()); end
    for (int i = 0; i < N && i < hs_dat.size(); i++) begin
      n_cmp++;
      if (hs_dat[i] !== DW'(i) || hs_idx[i] !== AW'(i) || hs_last[i] !== (i == N - 1) || (hs_t[i] + 5 - t0) / 10 != longint'(3 + i)) begin
        n_bad++; $display("FAIL seq_beat%0d: data=%h idx=%0d last=%b edge=E%0d, required %h/%0d/%b/E%0d",
                          i, hs_dat[i], hs_idx[i], hs_last[i], (hs_t[i] + 5 - t0) / 10, i, i, (i == N - 1), 3 + i);
      end
    end
    n_cmp++; if (rd_a.size() != N) begin n_bad++; $display("FAIL seq_reads: %0d, required 64", rd_a.size()); end
    for (int i = 0; i < N && i < rd_a.size(); i++) begin
      n_cmp++;
      if (rd_a[i] !== AW'(i) || (rd_t[i] - 5 - t0) / 10 != longint'(i)) begin
        n_bad++; $display("FAIL seq_read%0d: addr=%0d cycle=E%0d, required %0d/E%0d", i, rd_a[i], (rd_t[i] - 5 - t0) / 10, i, i);
      end
    end
    n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL seq_status: done=%b busy=%b, required 1/0", done, busy); end
    n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL seq_checksum: %h, required 0", checksum); end
  endtask

  task automatic test_negative();
    longint de;
    for (int i = 0; i < N; i++) mem[i] = DW'(-i);
    out_ready = 1'b1;
    start_run();
    wait_done(200, de);
    n_cmp++; if (hs_dat.size() != N) begin n_bad++; $display("FAIL neg_beats: %0d, required 64", hs_dat.size()); end
    n_cmp++; if (hs_dat.size() > 1 && hs_dat[1] !== 19'h7FFFF) begin n_bad++; $display("FAIL neg_idx1: %h, required 7ffff", hs_dat[1]); end
    n_cmp++; if (hs_dat.size() == N && hs_dat[63] !== 19'h7FFC1) begin n_bad++; $display("FAIL neg_idx63: %h, required 7ffc1", hs_dat[63]); end
    for (int i = 0; i < N && i < hs_dat.size(); i++) begin
      n_cmp++;
      if (hs_dat[i] !== DW'(-i) || hs_idx[i] !== AW'(i)) begin
        n_bad++; $display("FAIL neg_beat%0d: data=%h idx=%0d, required %h/%0d", i, hs_dat[i], hs_idx[i], DW'(-i), i);
      end
    end
    n_cmp++; if (checksum !== 19'h7FFC0) begin n_bad++; $display("FAIL neg_checksum: %h, required 7ffc0", checksum); end
  endtask

  task automatic test_restart();
    longint de;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rs_pre_done: %b, required 1", done); end
    for (int i = 0; i < N; i++) mem[i] = 19'h3FFFF;
    out_ready = 1'b1;
    start_run();
    @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b01) begin n_bad++; $display("FAIL rs_start: done=%b busy=%b, required 0/1", done, busy); end
    n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL rs_cks_clear: %h, required 0", checksum); end
    wait_done(200, de);
    n_cmp++; if (de != 66) begin n_bad++; $display("FAIL rs_done_edge: E%0d, required E66", de); end
    n_cmp++; if (hs_dat.size() != N) begin n_bad++; $display("FAIL rs_beats: %0d, required 64", hs_dat.size()); end
    for (int i = 0; i < N && i < hs_dat.size(); i++) begin
      n_cmp++;
      if (hs_dat[i] !== 19'h3FFFF || hs_idx[i] !== AW'(i)) begin
        n_bad++; $display("FAIL rs_beat%0d: data=%h idx=%0d, required 3ffff/%0d", i, hs_dat[i], hs_idx[i], i);
      end
    end
    n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL rs_checksum: %h, required 0", checksum); end
  endtask

  task automatic test_backpressure();
    int  phase, k;
    bit  alt, finished;
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    out_ready = 1'b1;
    phase = 0; k = 0; alt = 1'b1; finished = 1'b0;
    start_run();
    for (int c = 0; c < 400; c++) begin
      if (phase == 0 && hs_dat.size() >= 6) phase = 1;
      if (phase == 1)      out_ready = 1'b0;
      else if (phase == 2) begin out_ready = alt; alt = ~alt; end
      else                 out_ready = 1'b1;
      @(negedge clk);
      if (phase == 1) begin
        n_cmp++;
        if ({out_valid, out_index, out_data, ram_rd_en} !== {1'b1, 6'd6, 19'd6, 1'b0}) begin
          n_bad++; $display("FAIL bp_stall%0d: valid=%b idx=%0d data=%h rd_en=%b, required 1/6/6/0", k, out_valid, out_index, out_data, ram_rd_en);
        end
        k++;
        if (k == 10) phase = 2;
      end
      if (done) begin finished = 1'b1; break; end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_cmp++; if (!finished) begin n_bad++; $display("FAIL bp_timeout: done=0 after 400 cycles, required 1"); end
    n_cmp++; if (hs_dat.size() != N) begin n_bad++; $display("FAIL bp_beats: %0d, required 64", hs_dat.size()); end
    for (int i = 0; i < N && i < hs_dat.size(); i++) begin
      n_cmp++;
      if (hs_dat[i] !== DW'(i) || hs_idx[i] !== AW'(i) || hs_last[i] !== (i == N - 1)) begin
        n_bad++; $display("FAIL bp_beat%0d: data=%h idx=%0d last=%b, required %h/%0d/%b", i, hs_dat[i], hs_idx[i], hs_last[i], i, i, (i == N - 1));
      end
    end
    n_cmp++; if (rd_a.size() != N) begin n_bad++; $display("FAIL bp_reads: %0d, required 64", rd_a.size()); end
    n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL bp_checksum: %h, required 0", checksum); end
  endtask

  task automatic test_start_in_run();
    longint de;
    bit     p10, p40;
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    out_ready = 1'b1;
    p10 = 1'b0; p40 = 1'b0; de = -1;
    start_run();
    for (int c = 0; c < 200; c++) begin
      start = 1'b0;
      if (!p10 && hs_dat.size() == 10) begin start = 1'b1; p10 = 1'b1; end
      if (!p40 && hs_dat.size() == 40) begin start = 1'b1; p40 = 1'b1; end
      @(negedge clk);
      if (done) begin de = (longint'($time) - 5 - t0) / 10; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++; if (de != 66) begin n_bad++; $display("FAIL sir_done_edge: E%0d, required E66", de); end
    n_cmp++; if (hs_dat.size() != N) begin n_bad++; $display("FAIL sir_beats: %0d, required 64", hs_dat.size()); end
    for (int i = 0; i < N && i < hs_dat.size(); i++) begin
      n_cmp++;
      if (hs_dat[i] !== DW'(i) || hs_idx[i] !== AW'(i) || (hs_t[i] + 5 - t0) / 10 != longint'(3 + i)) begin
        n_bad++; $display("FAIL sir_beat%0d: data=%h idx=%0d edge=E%0d, required %h/%0d/E%0d", i, hs_dat[i], hs_idx[i], (hs_t[i] + 5 - t0) / 10, i, i, 3 + i);
      end
    end
    n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL sir_checksum: %h, required 0", checksum); end
  endtask

  task automatic test_reset_mid();
    longint de;
    for (int i = 0; i < N; i++) mem[i] = DW'(i + 100);
    out_ready = 1'b1;
    start_run();
    for (int c = 0; c < 100 && hs_dat.size() < 20; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({ram_rd_en, ram_addr, busy, done} !== '0) begin n_bad++; $display("FAIL rm_ctrl: rd_en=%b addr=%0d busy=%b done=%b, required all 0", ram_rd_en, ram_addr, busy, done); end
    n_cmp++; if ({out_valid, out_last, out_index, out_data, checksum} !== '0) begin n_bad++; $display("FAIL rm_out: valid=%b last=%b idx=%0d data=%h cks=%h, required all 0", out_valid, out_last, out_index, out_data, checksum); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, ram_rd_en} !== 3'b000) begin
        n_bad++; $display("FAIL rm_idle%0d: valid=%b busy=%b rd_en=%b, required 000", c, out_valid, busy, ram_rd_en);
      end
    end
    start_run();
    wait_done(200, de);
    n_cmp++; if (de != 66) begin n_bad++; $display("FAIL rm_done_edge: E%0d, required E66", de); end
    n_cmp++; if (hs_dat.size() != N) begin n_bad++; $display("FAIL rm_beats: %0d, required 64", hs_dat.size()); end
    for (int i = 0; i < N && i < hs_dat.size(); i++) begin
      n_cmp++;
      if (hs_dat[i] !== DW'(i + 100) || hs_idx[i] !== AW'(i)) begin
        n_bad++; $display("FAIL rm_beat%0d: data=%h idx=%0d, required %h/%0d", i, hs_dat[i], hs_idx[i], DW'(i + 100), i);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; t0 = 0;
    test_reset();
    test_sequential();
    test_negative();
    test_restart();
    test_backpressure();
    test_start_in_run();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
